// File: rtl/tile_tl_quiesce_buffer_if.sv
// TileLink A/D channel bundle between the tile and the system bus.
// The slave view belongs to the quiesce buffer; master is the far side.
interface tile_tl_quiesce_buffer_if #(
  parameter int SW = 3,
  parameter int BB = 8
);
  localparam int DW = 8 * BB;

  logic          in_a_valid;
  logic          in_a_ready;
  logic [2:0]    in_a_bits_opcode;
  logic [2:0]    in_a_bits_param;
  logic [3:0]    in_a_bits_size;
  logic [SW-1:0] in_a_bits_source;
  logic [31:0]   in_a_bits_address;
  logic [BB-1:0] in_a_bits_mask;
  logic [DW-1:0] in_a_bits_data;

  logic          out_a_valid;
  logic          out_a_ready;
  logic [2:0]    out_a_bits_opcode;
  logic [2:0]    out_a_bits_param;
  logic [3:0]    out_a_bits_size;
  logic [SW-1:0] out_a_bits_source;
  logic [31:0]   out_a_bits_address;
  logic [BB-1:0] out_a_bits_mask;
  logic [DW-1:0] out_a_bits_data;

  logic          in_d_valid;
  logic          in_d_ready;
  logic [2:0]    in_d_bits_opcode;
  logic [1:0]    in_d_bits_param;
  logic [3:0]    in_d_bits_size;
  logic [SW-1:0] in_d_bits_source;
  logic [2:0]    in_d_bits_sink;
  logic          in_d_bits_denied;
  logic [DW-1:0] in_d_bits_data;
  logic          in_d_bits_corrupt;

  logic          out_d_valid;
  logic          out_d_ready;
  logic [2:0]    out_d_bits_opcode;
  logic [1:0]    out_d_bits_param;
  logic [3:0]    out_d_bits_size;
  logic [SW-1:0] out_d_bits_source;
  logic [2:0]    out_d_bits_sink;
  logic          out_d_bits_denied;
  logic [DW-1:0] out_d_bits_data;
  logic          out_d_bits_corrupt;

  modport slave (
    input  in_a_valid, in_a_bits_opcode, in_a_bits_param,
           in_a_bits_size, in_a_bits_source, in_a_bits_address,
           in_a_bits_mask, in_a_bits_data,
    output in_a_ready,
    output out_a_valid, out_a_bits_opcode, out_a_bits_param,
           out_a_bits_size, out_a_bits_source, out_a_bits_address,
           out_a_bits_mask, out_a_bits_data,
    input  out_a_ready,
    input  in_d_valid, in_d_bits_opcode, in_d_bits_param,
           in_d_bits_size, in_d_bits_source, in_d_bits_sink,
           in_d_bits_denied, in_d_bits_data, in_d_bits_corrupt,
    output in_d_ready,
    output out_d_valid, out_d_bits_opcode, out_d_bits_param,
           out_d_bits_size, out_d_bits_source, out_d_bits_sink,
           out_d_bits_denied, out_d_bits_data, out_d_bits_corrupt,
    input  out_d_ready
  );

  modport master (
    output in_a_valid, in_a_bits_opcode, in_a_bits_param,
           in_a_bits_size, in_a_bits_source, in_a_bits_address,
           in_a_bits_mask, in_a_bits_data,
    input  in_a_ready,
    input  out_a_valid, out_a_bits_opcode, out_a_bits_param,
           out_a_bits_size, out_a_bits_source, out_a_bits_address,
           out_a_bits_mask, out_a_bits_data,
    output out_a_ready,
    output in_d_valid, in_d_bits_opcode, in_d_bits_param,
           in_d_bits_size, in_d_bits_source, in_d_bits_sink,
           in_d_bits_denied, in_d_bits_data, in_d_bits_corrupt,
    input  in_d_ready,
    input  out_d_valid, out_d_bits_opcode, out_d_bits_param,
           out_d_bits_size, out_d_bits_source, out_d_bits_sink,
           out_d_bits_denied, out_d_bits_data, out_d_bits_corrupt,
    output out_d_ready
  );
endinterface

// File: rtl/tile_tl_quiesce_buffer.sv
// Tile TileLink A/D buffer: 2-deep A queue, per-source in-flight
// tracking and a quiesce handshake that gates tile reset.
module tile_tl_quiesce_buffer #(
  parameter int SOURCES    = 8,
  parameter int BEAT_BYTES = 8
) (
  input  logic clock,
  input  logic reset,
  tile_tl_quiesce_buffer_if.slave bus,
  input  logic       quiesce_req,
  output logic       quiesced,
  output logic [3:0] outstanding,
  output logic       err_dup_source,
  output logic       err_unexpected_d
);
  localparam int SW = $clog2(SOURCES);
  localparam int DW = 8 * BEAT_BYTES;

  typedef struct packed {
    logic                  first;
    logic [2:0]            opcode;
    logic [2:0]            param;
    logic [3:0]            size;
    logic [SW-1:0]         source;
    logic [31:0]           address;
    logic [BEAT_BYTES-1:0] mask;
    logic [DW-1:0]         data;
  } a_beat_t;

  function automatic logic [3:0] len_f(
    input logic       multi,
    input logic [3:0] size
  );
    logic [15:0] b;
    b = 16'd1;
    if (multi && size > 4'd3)
      b = 16'd1 << (size - 4'd3);
    return 4'(b - 16'd1);
  endfunction

  a_beat_t ent0_q, ent0_d;
  a_beat_t ent1_q, ent1_d;
  a_beat_t in_beat;
  logic [1:0] cnt_q, cnt_d;
  logic [3:0] a_cnt_q, a_cnt_d;
  logic [3:0] d_cnt_q, d_cnt_d;
  logic [SOURCES-1:0] busy_q, busy_d;
  logic [3:0] outs_q, outs_d;
  logic quiesced_q, quiesced_d;
  logic dup_q, dup_d;
  logic unexp_q, unexp_d;

  logic a_first, gate, full, enq, deq;
  logic a_multi, d_multi, d_fire, d_first, d_last, d_rel;
  logic set_en, clr_en;
  logic [3:0] a_rem, d_rem;

  // A beat counter sits at the input so quiesce never cuts a burst
  assign a_first = (a_cnt_q == 4'd0);
  assign gate    = quiesce_req && a_first;
  assign full    = (cnt_q == 2'd2);
  assign bus.in_a_ready  = !full && !gate;
  assign bus.out_a_valid = (cnt_q != 2'd0);
  assign enq = bus.in_a_valid && bus.in_a_ready;
  assign deq = bus.out_a_valid && bus.out_a_ready;

  assign bus.out_a_bits_opcode  = ent0_q.opcode;
  assign bus.out_a_bits_param   = ent0_q.param;
  assign bus.out_a_bits_size    = ent0_q.size;
  assign bus.out_a_bits_source  = ent0_q.source;
  assign bus.out_a_bits_address = ent0_q.address;
  assign bus.out_a_bits_mask    = ent0_q.mask;
  assign bus.out_a_bits_data    = ent0_q.data;

  assign bus.out_d_valid        = bus.in_d_valid;
  assign bus.in_d_ready         = bus.out_d_ready;
  assign bus.out_d_bits_opcode  = bus.in_d_bits_opcode;
  assign bus.out_d_bits_param   = bus.in_d_bits_param;
  assign bus.out_d_bits_size    = bus.in_d_bits_size;
  assign bus.out_d_bits_source  = bus.in_d_bits_source;
  assign bus.out_d_bits_sink    = bus.in_d_bits_sink;
  assign bus.out_d_bits_denied  = bus.in_d_bits_denied;
  assign bus.out_d_bits_data    = bus.in_d_bits_data;
  assign bus.out_d_bits_corrupt = bus.in_d_bits_corrupt;

  assign quiesced         = quiesced_q;
  assign outstanding      = outs_q;
  assign err_dup_source   = dup_q;
  assign err_unexpected_d = unexp_q;

  always_comb begin
    a_multi = (bus.in_a_bits_opcode == 3'd0) ||
              (bus.in_a_bits_opcode == 3'd1);
    a_rem   = a_first ? len_f(a_multi, bus.in_a_bits_size)
                      : a_cnt_q - 4'd1;
    a_cnt_d = enq ? a_rem : a_cnt_q;

    in_beat = '{
      first:   a_first,
      opcode:  bus.in_a_bits_opcode,
      param:   bus.in_a_bits_param,
      size:    bus.in_a_bits_size,
      source:  bus.in_a_bits_source,
      address: bus.in_a_bits_address,
      mask:    bus.in_a_bits_mask,
      data:    bus.in_a_bits_data
    };

    ent0_d = ent0_q;
    ent1_d = ent1_q;
    cnt_d  = cnt_q;
    unique case ({enq, deq})
      2'b10: begin
        if (cnt_q == 2'd0) ent0_d = in_beat;
        else               ent1_d = in_beat;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        ent0_d = ent1_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          ent0_d = in_beat;
        end else begin
          ent0_d = ent1_q;
          ent1_d = in_beat;
        end
      end
      default: ;
    endcase

    d_fire  = bus.in_d_valid && bus.out_d_ready;
    d_first = (d_cnt_q == 4'd0);
    d_rel   = (bus.in_d_bits_opcode == 3'd6);
    d_multi = (bus.in_d_bits_opcode == 3'd1) ||
              (bus.in_d_bits_opcode == 3'd5);
    d_rem   = d_first ? len_f(d_multi, bus.in_d_bits_size)
                      : d_cnt_q - 4'd1;
    d_last  = (d_rem == 4'd0);
    d_cnt_d = d_fire ? d_rem : d_cnt_q;

    // clear before set so a same-source retire+issue stays busy
    set_en = deq && ent0_q.first;
    clr_en = d_fire && d_last && !d_rel;
    busy_d = busy_q;
    if (clr_en) busy_d[bus.in_d_bits_source] = 1'b0;
    if (set_en) busy_d[ent0_q.source] = 1'b1;

    dup_d   = dup_q ||
              (set_en && busy_q[ent0_q.source]);
    unexp_d = unexp_q ||
              (d_fire && d_first && !d_rel &&
               !busy_q[bus.in_d_bits_source]);

    outs_d = '0;
    for (int i = 0; i < SOURCES; i++)
      outs_d = outs_d + 4'(busy_q[i]);

    quiesced_d = quiesce_req && (cnt_q == 2'd0) && a_first &&
                 (busy_q == '0) && d_first;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ent0_q     <= '0;
      ent1_q     <= '0;
      cnt_q      <= '0;
      a_cnt_q    <= '0;
      d_cnt_q    <= '0;
      busy_q     <= '0;
      outs_q     <= '0;
      quiesced_q <= 1'b0;
      dup_q      <= 1'b0;
      unexp_q    <= 1'b0;
    end else begin
      ent0_q     <= ent0_d;
      ent1_q     <= ent1_d;
      cnt_q      <= cnt_d;
      a_cnt_q    <= a_cnt_d;
      d_cnt_q    <= d_cnt_d;
      busy_q     <= busy_d;
      outs_q     <= outs_d;
      quiesced_q <= quiesced_d;
      dup_q      <= dup_d;
      unexp_q    <= unexp_d;
    end
  end
endmodule
